// File: rtl/axi4_ram_responder.sv
// AXI4 subordinate backed by a byte-strobed RAM; one transaction in flight at a time.
// B and R return the captured ID and echo fields unchanged.
module axi4_ram_responder #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [30:0] BASE_ADDR   = 31'h1000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_aw_ready,
    input  logic        auto_in_aw_valid,
    input  logic [3:0]  auto_in_aw_bits_id,
    input  logic [30:0] auto_in_aw_bits_addr,
    input  logic [7:0]  auto_in_aw_bits_len,
    input  logic [2:0]  auto_in_aw_bits_size,
    input  logic [1:0]  auto_in_aw_bits_burst,
    input  logic        auto_in_aw_bits_lock,
    input  logic [3:0]  auto_in_aw_bits_cache,
    input  logic [2:0]  auto_in_aw_bits_prot,
    input  logic [3:0]  auto_in_aw_bits_qos,
    input  logic [3:0]  auto_in_aw_bits_echo_tl_state_size,
    input  logic [4:0]  auto_in_aw_bits_echo_tl_state_source,
    output logic        auto_in_w_ready,
    input  logic        auto_in_w_valid,
    input  logic [63:0] auto_in_w_bits_data,
    input  logic [7:0]  auto_in_w_bits_strb,
    input  logic        auto_in_w_bits_last,
    input  logic        auto_in_b_ready,
    output logic        auto_in_b_valid,
    output logic [3:0]  auto_in_b_bits_id,
    output logic [1:0]  auto_in_b_bits_resp,
    output logic [3:0]  auto_in_b_bits_echo_tl_state_size,
    output logic [4:0]  auto_in_b_bits_echo_tl_state_source,
    output logic        auto_in_ar_ready,
    input  logic        auto_in_ar_valid,
    input  logic [3:0]  auto_in_ar_bits_id,
    input  logic [30:0] auto_in_ar_bits_addr,
    input  logic [7:0]  auto_in_ar_bits_len,
    input  logic [2:0]  auto_in_ar_bits_size,
    input  logic [1:0]  auto_in_ar_bits_burst,
    input  logic        auto_in_ar_bits_lock,
    input  logic [3:0]  auto_in_ar_bits_cache,
    input  logic [2:0]  auto_in_ar_bits_prot,
    input  logic [3:0]  auto_in_ar_bits_qos,
    input  logic [3:0]  auto_in_ar_bits_echo_tl_state_size,
    input  logic [4:0]  auto_in_ar_bits_echo_tl_state_source,
    input  logic        auto_in_r_ready,
    output logic        auto_in_r_valid,
    output logic [3:0]  auto_in_r_bits_id,
    output logic [63:0] auto_in_r_bits_data,
    output logic [1:0]  auto_in_r_bits_resp,
    output logic [3:0]  auto_in_r_bits_echo_tl_state_size,
    output logic [4:0]  auto_in_r_bits_echo_tl_state_source,
    output logic        auto_in_r_bits_last
);
    localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] Limit = {1'b0, BASE_ADDR} + 32'(DEPTH_WORDS * 8);

    typedef enum logic [1:0] {StIdle, StWdata, StWresp, StRdata} state_e;

    function automatic logic is_hit(input logic [30:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < Limit);
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [30:0] a);
        return IdxW'((a - BASE_ADDR) >> 3);
    endfunction

    function automatic logic [30:0] next_addr(input logic [30:0] a, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [30:0] inc, mask, res;
        inc  = 31'(1) << size;
        mask = ((31'(len) + 31'(1)) << size) - 31'(1);
        case (burst)
            2'b00:   res = a;
            2'b10:   res = (a & ~mask) | ((a + inc) & mask);
            default: res = a + inc;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] resp_code(input logic hit, input logic slverr);
        return !hit ? 2'b11 : (slverr ? 2'b10 : 2'b00);
    endfunction

    state_e      state_q, state_d;
    logic        prio_read_q;
    logic [3:0]  id_q, esz_q;
    logic [4:0]  src_q;
    logic [30:0] addr_q;
    logic [7:0]  len_q, beat_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        hit_q, past_q;
    logic        r_valid_q, r_last_q, b_valid_q;
    logic [63:0] r_data_q;
    logic [1:0]  r_resp_q, b_resp_q;
    logic [63:0] mem [DEPTH_WORDS];

    logic        ar_fire, aw_fire, w_fire, r_fire, b_fire;
    logic [30:0] start_addr, nxt_addr;
    logic        start_hit;

    assign auto_in_ar_ready = (state_q == StIdle) & ~(auto_in_aw_valid & ~prio_read_q);
    assign auto_in_aw_ready = (state_q == StIdle) & ~(auto_in_ar_valid & prio_read_q);
    assign auto_in_w_ready  = (state_q == StWdata);

    assign ar_fire = auto_in_ar_valid & auto_in_ar_ready;
    assign aw_fire = auto_in_aw_valid & auto_in_aw_ready;
    assign w_fire  = auto_in_w_valid & auto_in_w_ready;
    assign r_fire  = r_valid_q & auto_in_r_ready;
    assign b_fire  = b_valid_q & auto_in_b_ready;

    assign start_addr = ar_fire ? auto_in_ar_bits_addr : auto_in_aw_bits_addr;
    assign start_hit  = is_hit(start_addr);
    assign nxt_addr   = next_addr(addr_q, size_q, len_q, burst_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ar_fire)      state_d = StRdata;
                else if (aw_fire) state_d = StWdata;
            end
            StWdata: if (w_fire && auto_in_w_bits_last) state_d = StWresp;
            StWresp: if (b_fire) state_d = StIdle;
            StRdata: if (r_fire && r_last_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            prio_read_q <= 1'b1;
            id_q        <= '0;
            esz_q       <= '0;
            src_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            hit_q       <= 1'b0;
            past_q      <= 1'b0;
            r_valid_q   <= 1'b0;
            r_last_q    <= 1'b0;
            r_data_q    <= '0;
            r_resp_q    <= '0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ar_fire || aw_fire) begin
                prio_read_q <= ~prio_read_q;
                id_q    <= ar_fire ? auto_in_ar_bits_id : auto_in_aw_bits_id;
                esz_q   <= ar_fire ? auto_in_ar_bits_echo_tl_state_size
                                   : auto_in_aw_bits_echo_tl_state_size;
                src_q   <= ar_fire ? auto_in_ar_bits_echo_tl_state_source
                                   : auto_in_aw_bits_echo_tl_state_source;
                addr_q  <= start_addr;
                len_q   <= ar_fire ? auto_in_ar_bits_len : auto_in_aw_bits_len;
                size_q  <= ar_fire ? auto_in_ar_bits_size : auto_in_aw_bits_size;
                burst_q <= ar_fire ? auto_in_ar_bits_burst : auto_in_aw_bits_burst;
                hit_q   <= start_hit;
                beat_q  <= '0;
                past_q  <= 1'b0;
            end
            if (ar_fire) begin
                r_valid_q <= 1'b1;
                r_data_q  <= start_hit ? mem[word_idx(start_addr)] : '0;
                r_resp_q  <= resp_code(start_hit, auto_in_ar_bits_burst == 2'b11);
                r_last_q  <= (auto_in_ar_bits_len == 8'd0);
            end
            if (r_fire) begin
                if (r_last_q) begin
                    r_valid_q <= 1'b0;
                end else begin
                    addr_q   <= nxt_addr;
                    beat_q   <= beat_q + 8'd1;
                    r_data_q <= hit_q ? mem[word_idx(nxt_addr)] : '0;
                    r_last_q <= (beat_q + 8'd1) == len_q;
                end
            end
            if (w_fire) begin
                addr_q <= nxt_addr;
                beat_q <= beat_q + 8'd1;
                // past_q marks beats beyond len so a wrapped counter never re-enables writes
                if (beat_q == len_q) past_q <= 1'b1;
                if (auto_in_w_bits_last) begin
                    b_valid_q <= 1'b1;
                    b_resp_q  <= resp_code(hit_q,
                                           burst_q == 2'b11 || past_q || beat_q != len_q);
                end
            end
            if (b_fire) b_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_fire && hit_q && !past_q) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_w_bits_strb[b]) begin
                    mem[word_idx(addr_q)][8*b +: 8] <= auto_in_w_bits_data[8*b +: 8];
                end
            end
        end
    end

    assign auto_in_b_valid                     = b_valid_q;
    assign auto_in_b_bits_id                   = id_q;
    assign auto_in_b_bits_resp                 = b_resp_q;
    assign auto_in_b_bits_echo_tl_state_size   = esz_q;
    assign auto_in_b_bits_echo_tl_state_source = src_q;
    assign auto_in_r_valid                     = r_valid_q;
    assign auto_in_r_bits_id                   = id_q;
    assign auto_in_r_bits_data                 = r_data_q;
    assign auto_in_r_bits_resp                 = r_resp_q;
    assign auto_in_r_bits_last                 = r_last_q;
    assign auto_in_r_bits_echo_tl_state_size   = esz_q;
    assign auto_in_r_bits_echo_tl_state_source = src_q;

    logic unused_ok;
    assign unused_ok = ^{auto_in_aw_bits_lock, auto_in_aw_bits_cache, auto_in_aw_bits_prot,
                         auto_in_aw_bits_qos, auto_in_ar_bits_lock, auto_in_ar_bits_cache,
                         auto_in_ar_bits_prot, auto_in_ar_bits_qos};
endmodule

// File: tb/tb_axi4_ram_responder.sv
// Directed bench for axi4_ram_responder: a transaction-level model predicts every B and R beat,
// a negedge monitor compares them, and literal checks pin the model.
module tb_axi4_ram_responder;
    localparam int unsigned Depth = 512;
    localparam logic [30:0] Base  = 31'h1000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        aw_ready, aw_valid;
    logic [3:0]  aw_id, aw_esz;
    logic [30:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [4:0]  aw_src;
    logic        ar_ready, ar_valid;
    logic [3:0]  ar_id, ar_esz;
    logic [30:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [4:0]  ar_src;
    logic        w_ready, w_valid, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_ready, b_valid;
    logic [3:0]  b_id, b_esz;
    logic [1:0]  b_resp;
    logic [4:0]  b_src;
    logic        r_ready, r_valid, r_last;
    logic [3:0]  r_id, r_esz;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [4:0]  r_src;

    axi4_ram_responder #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base)) dut (
        .clock(clock), .reset(reset),
        .auto_in_aw_ready(aw_ready), .auto_in_aw_valid(aw_valid), .auto_in_aw_bits_id(aw_id),
        .auto_in_aw_bits_addr(aw_addr), .auto_in_aw_bits_len(aw_len),
        .auto_in_aw_bits_size(aw_size), .auto_in_aw_bits_burst(aw_burst),
        .auto_in_aw_bits_lock(1'b1), .auto_in_aw_bits_cache(4'h3), .auto_in_aw_bits_prot(3'h2),
        .auto_in_aw_bits_qos(4'h0), .auto_in_aw_bits_echo_tl_state_size(aw_esz),
        .auto_in_aw_bits_echo_tl_state_source(aw_src),
        .auto_in_w_ready(w_ready), .auto_in_w_valid(w_valid), .auto_in_w_bits_data(w_data),
        .auto_in_w_bits_strb(w_strb), .auto_in_w_bits_last(w_last),
        .auto_in_b_ready(b_ready), .auto_in_b_valid(b_valid), .auto_in_b_bits_id(b_id),
        .auto_in_b_bits_resp(b_resp), .auto_in_b_bits_echo_tl_state_size(b_esz),
        .auto_in_b_bits_echo_tl_state_source(b_src),
        .auto_in_ar_ready(ar_ready), .auto_in_ar_valid(ar_valid), .auto_in_ar_bits_id(ar_id),
        .auto_in_ar_bits_addr(ar_addr), .auto_in_ar_bits_len(ar_len),
        .auto_in_ar_bits_size(ar_size), .auto_in_ar_bits_burst(ar_burst),
        .auto_in_ar_bits_lock(1'b1), .auto_in_ar_bits_cache(4'h3), .auto_in_ar_bits_prot(3'h2),
        .auto_in_ar_bits_qos(4'h0), .auto_in_ar_bits_echo_tl_state_size(ar_esz),
        .auto_in_ar_bits_echo_tl_state_source(ar_src),
        .auto_in_r_ready(r_ready), .auto_in_r_valid(r_valid), .auto_in_r_bits_id(r_id),
        .auto_in_r_bits_data(r_data), .auto_in_r_bits_resp(r_resp),
        .auto_in_r_bits_echo_tl_state_size(r_esz), .auto_in_r_bits_echo_tl_state_source(r_src),
        .auto_in_r_bits_last(r_last)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  esz;
        logic [4:0]  src;
    } rbeat_t;
    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
        logic [3:0] esz;
        logic [4:0] src;
    } bresp_t;

    rbeat_t      exp_r[$];
    bresp_t      exp_b[$];
    logic [63:0] got_r[$];
    bresp_t      got_b;
    logic [63:0] mem_m [Depth];
    logic [63:0] wd[$];
    logic [7:0]  ws[$];
    logic        wl[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Model address map and burst sequencing using plain modular arithmetic.
    function automatic bit m_hit(input logic [30:0] a);
        longint unsigned x, lo;
        x  = 64'(a);
        lo = 64'(Base);
        return (x >= lo) && (x < lo + 64'(Depth) * 8);
    endfunction

    function automatic int m_idx(input logic [30:0] a);
        longint unsigned off;
        off = (64'(a) + 64'h8000_0000 - 64'(Base)) % 64'h8000_0000;
        return int'((off / 8) % 64'(Depth));
    endfunction

    function automatic logic [30:0] m_next(input logic [30:0] a, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst);
        longint unsigned inc, total, la, lower;
        inc   = 64'(1) << size;
        total = (64'(len) + 1) * inc;
        la    = 64'(a);
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            lower = la % total;
            la    = la - lower + (lower + inc) % total;
        end else begin
            la = la + inc;
        end
        return 31'(la % 64'h8000_0000);
    endfunction

    task automatic model_read(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [3:0] esz, input logic [4:0] src);
        logic [30:0] a;
        bit          hit;
        rbeat_t      e;
        a   = addr;
        hit = m_hit(addr);
        for (int i = 0; i <= int'(len); i++) begin
            e.data = hit ? mem_m[m_idx(a)] : 64'h0;
            e.resp = !hit ? 2'd3 : ((burst == 2'b11) ? 2'd2 : 2'd0);
            e.last = (i == int'(len));
            e.id   = id;
            e.esz  = esz;
            e.src  = src;
            exp_r.push_back(e);
            a = m_next(a, size, len, burst);
        end
    endtask

    task automatic model_write(input logic [3:0] id, input logic [30:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [3:0] esz,
                               input logic [4:0] src);
        logic [30:0] a;
        bit          hit;
        int          last_i;
        bresp_t      e;
        a      = addr;
        hit    = m_hit(addr);
        last_i = -1;
        for (int i = 0; i < wd.size(); i++) begin
            if (hit && i <= int'(len)) begin
                for (int b = 0; b < 8; b++) begin
                    if (ws[i][b]) mem_m[m_idx(a)][8*b +: 8] = wd[i][8*b +: 8];
                end
            end
            a = m_next(a, size, len, burst);
            if (wl[i]) begin
                last_i = i;
                break;
            end
        end
        e.resp = !hit ? 2'd3 : ((burst == 2'b11 || last_i != int'(len)) ? 2'd2 : 2'd0);
        e.id   = id;
        e.esz  = esz;
        e.src  = src;
        exp_b.push_back(e);
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] esz, input logic [4:0] src);
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        ar_esz = esz; ar_src = src;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] esz, input logic [4:0] src);
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        aw_esz = esz; aw_src = src;
    endtask

    task automatic hs_ar();
        int n = 0;
        ar_valid = 1'b1;
        @(negedge clock);
        while (!ar_ready && n < 50) begin @(negedge clock); n++; end
        if (!ar_ready) check("ar_handshake_timeout", 64'(ar_ready), 64'd1);
        @(posedge clock); #1;
        ar_valid = 1'b0;
    endtask

    task automatic hs_aw();
        int n = 0;
        aw_valid = 1'b1;
        @(negedge clock);
        while (!aw_ready && n < 50) begin @(negedge clock); n++; end
        if (!aw_ready) check("aw_handshake_timeout", 64'(aw_ready), 64'd1);
        @(posedge clock); #1;
        aw_valid = 1'b0;
    endtask

    task automatic send_w();
        int n;
        for (int i = 0; i < wd.size(); i++) begin
            w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = wl[i];
            n = 0;
            @(negedge clock);
            while (!w_ready && n < 50) begin @(negedge clock); n++; end
            if (!w_ready) check("w_handshake_timeout", 64'(w_ready), 64'd1);
            @(posedge clock); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(negedge clock); n++;
        end
        check("response_timeout", 64'(exp_r.size() + exp_b.size()), 64'd0);
        exp_r.delete();
        exp_b.delete();
        @(posedge clock); #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] esz, input logic [4:0] src);
        model_write(id, addr, len, size, burst, esz, src);
        set_aw(id, addr, len, size, burst, esz, src);
        hs_aw();
        send_w();
        wait_idle();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] esz, input logic [4:0] src);
        got_r.delete();
        model_read(id, addr, len, size, burst, esz, src);
        set_ar(id, addr, len, size, burst, esz, src);
        hs_ar();
        wait_idle();
    endtask

    task automatic one_beat(input logic [63:0] d, input logic [7:0] s);
        wd.delete(); ws.delete(); wl.delete();
        wd.push_back(d); ws.push_back(s); wl.push_back(1'b1);
    endtask

    // Monitor: compares every B/R handshake with the model and checks R stays put while stalled.
    logic        held = 1'b0;
    logic [63:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    logic [3:0]  h_id;
    rbeat_t      er;
    bresp_t      eb;
    always @(negedge clock) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("r_hold_valid", 64'(r_valid), 64'd1);
                check("r_hold_data", r_data, h_data);
                check("r_hold_resp", 64'(r_resp), 64'(h_resp));
                check("r_hold_last", 64'(r_last), 64'(h_last));
                check("r_hold_id", 64'(r_id), 64'(h_id));
            end
            held = r_valid && !r_ready;
            h_data = r_data; h_resp = r_resp; h_last = r_last; h_id = r_id;
            if (r_valid || b_valid || w_ready) begin
                check("busy_no_addr_ready", 64'({aw_ready, ar_ready}), 64'd0);
            end
            if (r_valid && r_ready) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 64'(r_valid), 64'd0);
                end else begin
                    er = exp_r.pop_front();
                    check("r_data", r_data, er.data);
                    check("r_resp", 64'(r_resp), 64'(er.resp));
                    check("r_last", 64'(r_last), 64'(er.last));
                    check("r_id", 64'(r_id), 64'(er.id));
                    check("r_echo", 64'({r_esz, r_src}), 64'({er.esz, er.src}));
                    got_r.push_back(r_data);
                end
            end
            if (b_valid && b_ready) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 64'(b_valid), 64'd0);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_resp", 64'(b_resp), 64'(eb.resp));
                    check("b_id", 64'(b_id), 64'(eb.id));
                    check("b_echo", 64'({b_esz, b_src}), 64'({eb.esz, eb.src}));
                    got_b = '{resp: b_resp, id: b_id, esz: b_esz, src: b_src};
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [63:0] lit [4];

    initial begin
        aw_valid = 0; ar_valid = 0; w_valid = 0; w_last = 0; w_data = '0; w_strb = '0;
        r_ready = 1; b_ready = 1;
        set_aw(0, '0, 0, 0, 0, 0, 0);
        set_ar(0, '0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_ar_ready", 64'(ar_ready), 64'd1);
        check("rst_aw_ready", 64'(aw_ready), 64'd1);
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_r_bits", {r_data[59:0], r_resp, r_last, 1'b0} | 64'({r_id, r_esz, r_src}),
              64'd0);
        check("rst_b_bits", 64'({b_id, b_resp, b_esz, b_src}), 64'd0);
        @(posedge clock); #1;

        // INCR write of four beats, then read back
        wd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        ws = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        wl = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_write(4'h5, Base, 8'd3, 3'd3, 2'b01, 4'h3, 5'h1A);
        check("t1_b_lit", 64'({got_b.id, got_b.resp, got_b.src}), 64'({4'h5, 2'd0, 5'h1A}));
        do_read(4'h5, Base, 8'd3, 3'd3, 2'b01, 4'h3, 5'h1A);
        check("t1_beat_count", 64'(got_r.size()), 64'd4);
        lit = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        for (int i = 0; i < got_r.size() && i < 4; i++) check("t1_data_lit", got_r[i], lit[i]);

        // Byte strobes
        one_beat(64'h0, 8'hFF);
        do_write(4'h2, Base, 8'd0, 3'd3, 2'b01, 4'h0, 5'h00);
        one_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        do_write(4'h2, Base, 8'd0, 3'd3, 2'b01, 4'h0, 5'h00);
        do_read(4'h2, Base, 8'd0, 3'd3, 2'b01, 4'h0, 5'h00);
        if (got_r.size() > 0) check("t2_strb_lit", got_r[0], 64'h0000_0000_FFFF_FFFF);
        else check("t2_no_beat", 64'(got_r.size()), 64'd1);

        // WRAP read starting mid-window
        do_read(4'h3, Base + 31'h10, 8'd3, 3'd3, 2'b10, 4'h1, 5'h07);
        lit = '{64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
                64'h0000_0000_FFFF_FFFF, 64'h2222_2222_2222_2222};
        check("t3_beat_count", 64'(got_r.size()), 64'd4);
        for (int i = 0; i < got_r.size() && i < 4; i++) check("t3_wrap_lit", got_r[i], lit[i]);

        // Decode miss on both channels; word 511 would alias BASE-8 if decode were skipped
        do_read(4'h4, Base - 31'h8, 8'd1, 3'd3, 2'b01, 4'h0, 5'h01);
        check("t4_miss_beats", 64'(got_r.size()), 64'd2);
        if (got_r.size() > 0) check("t4_miss_data_lit", got_r[0], 64'h0);
        one_beat(64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
        do_write(4'h4, Base + 31'hFF8, 8'd0, 3'd3, 2'b01, 4'h0, 5'h01);
        one_beat(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        do_write(4'h4, Base - 31'h8, 8'd0, 3'd3, 2'b01, 4'h0, 5'h01);
        check("t4_miss_bresp_lit", 64'(got_b.resp), 64'd3);
        do_read(4'h4, Base + 31'hFF8, 8'd0, 3'd3, 2'b01, 4'h0, 5'h01);
        if (got_r.size() > 0) check("t4_ram_unchanged_lit", got_r[0], 64'hA5A5_A5A5_A5A5_A5A5);
        else check("t4_no_beat", 64'(got_r.size()), 64'd1);

        // Arbitration from reset: AR first, then AW on the next tie
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        got_r.delete();
        model_read(4'h6, Base, 8'd0, 3'd3, 2'b01, 4'h0, 5'h02);
        set_ar(4'h6, Base, 8'd0, 3'd3, 2'b01, 4'h0, 5'h02);
        set_aw(4'h7, Base + 31'h20, 8'd0, 3'd3, 2'b01, 4'h0, 5'h03);
        ar_valid = 1'b1; aw_valid = 1'b1;
        @(negedge clock);
        check("t5_first_grant", 64'({ar_ready, aw_ready}), 64'b10);
        @(posedge clock); #1;
        ar_valid = 1'b0; aw_valid = 1'b0;
        wait_idle();
        if (got_r.size() > 0) check("t5_read_lit", got_r[0], 64'h0000_0000_FFFF_FFFF);
        else check("t5_no_beat", 64'(got_r.size()), 64'd1);
        one_beat(64'h5555_5555_5555_5555, 8'hFF);
        model_write(4'h7, Base + 31'h20, 8'd0, 3'd3, 2'b01, 4'h0, 5'h03);
        ar_valid = 1'b1; aw_valid = 1'b1;
        @(negedge clock);
        check("t5_second_grant", 64'({ar_ready, aw_ready}), 64'b01);
        @(posedge clock); #1;
        ar_valid = 1'b0; aw_valid = 1'b0;
        send_w();
        wait_idle();
        do_read(4'h7, Base + 31'h20, 8'd0, 3'd3, 2'b01, 4'h0, 5'h03);

        // Early w_last gives SLVERR
        wd = '{64'hC0C0_C0C0_C0C0_C0C0, 64'hD1D1_D1D1_D1D1_D1D1};
        ws = '{8'hFF, 8'hFF};
        wl = '{1'b0, 1'b1};
        do_write(4'h8, Base + 31'h40, 8'd3, 3'd3, 2'b01, 4'h2, 5'h04);
        check("t6_slverr_lit", 64'(got_b.resp), 64'd2);

        // Stall R for five cycles mid-burst
        r_ready = 1'b0;
        got_r.delete();
        model_read(4'h9, Base, 8'd2, 3'd3, 2'b01, 4'h5, 5'h05);
        set_ar(4'h9, Base, 8'd2, 3'd3, 2'b01, 4'h5, 5'h05);
        hs_ar();
        repeat (5) @(posedge clock);
        #1 r_ready = 1'b1;
        wait_idle();
        check("t6_hold_beats", 64'(got_r.size()), 64'd3);

        // Reset in the middle of a stalled read burst
        r_ready = 1'b0;
        set_ar(4'hA, Base, 8'd3, 3'd3, 2'b01, 4'h0, 5'h06);
        hs_ar();
        @(negedge clock);
        check("t6_burst_live", 64'(r_valid), 64'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        check("t6_reset_r_valid", 64'(r_valid), 64'd0);
        reset = 1'b0; r_ready = 1'b1;
        @(negedge clock);
        check("t6_reset_ar_ready", 64'(ar_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_no_r_after_reset", 64'(r_valid), 64'd0);
        end
        @(posedge clock); #1;
        do_read(4'hB, Base + 31'h40, 8'd1, 3'd3, 2'b01, 4'h0, 5'h07);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
